// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier with a fixed WIDTH-cycle latency
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     sum_d;
  logic [CW-1:0]      cnt_q;
  // The add keeps its carry so the shifted-in top bit is never lost
  always_comb begin
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mplier_q[0] ? mcand_q : {WIDTH{1'b0}}};
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      product  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand_q  <= a;
          mplier_q <= b;
          acc_q    <= '0;
          cnt_q    <= '0;
          product  <= '0;
          busy     <= 1'b1;
          state_q  <= BUSY;
        end
        BUSY: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            product <= acc_d;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed self-checking bench for the shift-and-add multiplier
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic [7:0]  product4;
  logic        busy4;
  logic        done4;
  int checks = 0;
  int failures = 0;
  int overlap = 0;
  always #5 clk = ~clk;
  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .product(product), .busy(busy), .done(done)
  );
  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .product(product4), .busy(busy4), .done(done4)
  );
  always @(negedge clk) if (busy && done) overlap++;
  task automatic edge1;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, output int bcnt, output int dedge,
                        output int dcnt, output logic [15:0] p0, output logic [15:0] p);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    edge1();
    start = 1'b0;
    p0 = product;
    bcnt = busy ? 1 : 0;
    dedge = -1;
    dcnt = 0;
    p = 'x;
    for (int k = 1; k <= 12; k++) begin
      edge1();
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dedge < 0) begin
          dedge = k;
          p = product;
        end
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    edge1();
    edge1();
    checks += 3;
    if (product !== 16'h0) begin failures++; $display("FAIL reset_product got=%h exp=0000", product); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_basic;
    int bc, de, dc;
    logic [15:0] p0, p;
    run_op(8'h0F, 8'h0F, bc, de, dc, p0, p);
    checks += 5;
    if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    if (de !== 8) begin failures++; $display("FAIL basic_done_edge got=%0d exp=8", de); end
    if (dc !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
    if (p !== 16'h00E1) begin failures++; $display("FAIL basic_product got=%h exp=00e1", p); end
    if (product !== 16'h00E1) begin failures++; $display("FAIL basic_held got=%h exp=00e1", product); end
  endtask
  task automatic test_carry;
    int bc, de, dc;
    logic [15:0] p0, p;
    run_op(8'hFF, 8'hFF, bc, de, dc, p0, p);
    checks += 3;
    if (p0 !== 16'h0) begin failures++; $display("FAIL start_clears_product got=%h exp=0000", p0); end
    if (p !== 16'hFE01) begin failures++; $display("FAIL carry_product got=%h exp=fe01", p); end
    if (de !== 8) begin failures++; $display("FAIL carry_done_edge got=%0d exp=8", de); end
    run_op(8'h00, 8'hA5, bc, de, dc, p0, p);
    checks += 3;
    if (p !== 16'h0) begin failures++; $display("FAIL zero_product got=%h exp=0000", p); end
    if (de !== 8) begin failures++; $display("FAIL zero_done_edge got=%0d exp=8", de); end
    if (bc !== 8) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=8", bc); end
  endtask
  task automatic test_ignore;
    int de = -1;
    int dc = 0;
    logic [15:0] p = 'x;
    @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    edge1();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin
        @(negedge clk);
        a = 8'hAA;
        b = 8'hBB;
        start = 1'b1;
      end
      edge1();
      start = 1'b0;
      if (done) begin
        dc++;
        if (de < 0) begin
          de = k;
          p = product;
        end
      end
    end
    checks += 3;
    if (p !== 16'h000F) begin failures++; $display("FAIL ignore_product got=%h exp=000f", p); end
    if (de !== 8) begin failures++; $display("FAIL ignore_done_edge got=%0d exp=8", de); end
    if (dc !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dc); end
  endtask
  task automatic test_abort;
    int dc = 0;
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    edge1();
    start = 1'b0;
    edge1();
    edge1();
    edge1();
    @(negedge clk);
    reset = 1'b1;
    edge1();
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (product !== 16'h0) begin failures++; $display("FAIL abort_product got=%h exp=0000", product); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edge1();
      if (done) dc++;
    end
    checks++;
    if (dc !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dc); end
  endtask
  task automatic test_back_to_back;
    int d1 = -1;
    int d2 = -1;
    logic b9 = 1'bx;
    logic b10 = 1'bx;
    logic [15:0] p = 'x;
    @(negedge clk);
    a = 8'd2;
    b = 8'd3;
    start = 1'b1;
    edge1();
    for (int k = 1; k <= 20; k++) begin
      edge1();
      if (k == 9) b9 = busy;
      if (k == 10) b10 = busy;
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          p = product;
        end else if (d2 < 0) d2 = k;
      end
      if (k == 18) start = 1'b0;
    end
    checks += 5;
    if (d1 !== 8) begin failures++; $display("FAIL b2b_first_done got=%0d exp=8", d1); end
    if (p !== 16'h0006) begin failures++; $display("FAIL b2b_product got=%h exp=0006", p); end
    if (b9 !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", b9); end
    if (b10 !== 1'b1) begin failures++; $display("FAIL b2b_reaccept got=%b exp=1", b10); end
    if (d2 !== 18) begin failures++; $display("FAIL b2b_second_done got=%0d exp=18", d2); end
  endtask
  task automatic test_reset_start;
    @(negedge clk);
    a = 8'h07;
    b = 8'h09;
    reset = 1'b1;
    start = 1'b1;
    edge1();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    edge1();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_busy got=%b exp=0", busy); end
    if (product !== 16'h0) begin failures++; $display("FAIL rst_start_product got=%h exp=0000", product); end
  endtask
  task automatic test_width4;
    int de = -1;
    logic [7:0] p = 'x;
    @(negedge clk);
    a4 = 4'hF;
    b4 = 4'hF;
    start4 = 1'b1;
    edge1();
    start4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      if (done4 && de < 0) begin
        de = k;
        p = product4;
      end
    end
    checks += 2;
    if (de !== 4) begin failures++; $display("FAIL w4_done_edge got=%0d exp=4", de); end
    if (p !== 8'hE1) begin failures++; $display("FAIL w4_product got=%h exp=e1", p); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore();
    test_abort();
    test_back_to_back();
    test_reset_start();
    test_width4();
    checks++;
    if (overlap !== 0) begin failures++; $display("FAIL busy_done_overlap got=%0d exp=0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter: WIDTH, 8, operand width in bits; legal range 2..16.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous, active-high; sampled on the rising clk edge only.
REQ-005 Port: start  input  1  request to begin a multiply; sampled on the rising clk edge.
REQ-006 Port: a  input  WIDTH  multiplicand, unsigned.
REQ-007 Port: b  input  WIDTH  multiplier, unsigned.
REQ-008 Port: product  output  2*WIDTH  unsigned result a*b.
REQ-009 Port: busy  output  1  high while a multiply is in progress.
REQ-010 Port: done  output  1  one-cycle strobe: product valid; drives the downstream accumulator register enable.

Function
REQ-011 State machine states SHALL be IDLE, BUSY and DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL latch a and b, clear the partial product and the step counter, and enter BUSY.
REQ-013 In IDLE with start=0, the block SHALL hold state, product and outputs.
REQ-014 Each BUSY edge SHALL perform one step:
- if the latched multiplier LSB=1, add the multiplicand into the upper half of the partial product;
- hold the add result with a carry bit (WIDTH+1 bits);
- shift the partial product and multiplier right by one;
- increment the counter.
REQ-015 After exactly WIDTH BUSY edges, the block SHALL enter DONE with product = a*b (mod 2^(2*WIDTH), never overflowing).
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: start sampled at edge E0 -> busy=1 from E0 through E(WIDTH), done=1 between E(WIDTH) and E(WIDTH+1).
- Latency SHALL be fixed and independent of operand values.
REQ-018 busy SHALL be 1 only in BUSY; done SHALL be 1 only in DONE; busy and done SHALL never both be 1.
REQ-019 product SHALL change only on entry to DONE, on reset, or on start acceptance (cleared to 0 at E0).
REQ-020 product SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-021 start asserted in BUSY or DONE SHALL be ignored (not queued); a and b changes after E0 SHALL not affect the result.
REQ-022 A start held high continuously SHALL be re-accepted on the first IDLE edge after DONE, giving back-to-back operations with one IDLE cycle between them.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, product=0, busy=0, done=0, and clear counter and internal operand registers.
REQ-024 reset SHALL take priority over start and over any in-flight operation; an aborted multiply SHALL produce no done strobe.
REQ-025 With reset=1 and start=1 on the same edge, the block SHALL be in IDLE afterwards with start not accepted.

Verification
REQ-026 WIDTH=8:
- a=0x0F, b=0x0F, start pulse at E0 -> busy=1 for 8 cycles;
- done=1 only after E8;
- product=0x00E1 from E8, held after done falls.
REQ-027 WIDTH=8, a=0xFF, b=0xFF -> product=0xFE01 after E8 (carry path exercised); a=0x00, b=0xA5 -> product=0x0000, done still after E8.
REQ-028 WIDTH=8:
- start a=3, b=5;
- change a/b and pulse start at E3 -> ignored;
- product=0x000F after E8, single done pulse.
REQ-029 WIDTH=8:
- start a=0x12, b=0x34;
- reset=1 at E4 -> after E4 IDLE, busy=0, product=0;
- no done within the next 10 cycles.
REQ-030 WIDTH=8, start held high with a=2, b=3 -> done after E8 (product=0x0006), next accept at E10, next done after E18.
REQ-031 WIDTH=4, a=0xF, b=0xF -> product=0xE1 after E4.
